// File: rtl/grid_scale_stream_source.sv
`default_nettype none
// ============================================================================
// Module   : grid_scale_stream_source
// Purpose  : Replays a (grid, scale) table once per data sample on two
//            independent AXI-Stream channels feeding the RSWAF activation.
// Revision : 1.0 - initial release
// ============================================================================

// One output channel: walks idx 0..len-1 for rep passes, registered outputs.
module grid_scale_stream_chan #(
    parameter int WIDTH = 16,
    parameter int AW    = 3,
    parameter int LW    = 4,
    parameter int RW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LW-1:0]    len,
    input  logic [RW-1:0]    rep,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             tready,
    output logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] tdata,
    output logic             tvalid,
    output logic             tlast,
    output logic             fin,
    output logic             final_hs
);

    logic [AW-1:0]    r_idx;
    logic [RW-1:0]    r_pass;
    logic             r_valid;
    logic             r_last;
    logic [WIDTH-1:0] r_data;
    logic             r_fin;

    logic w_hs;
    logic w_end;
    logic w_last_pass;

    assign w_hs        = r_valid & tready;
    assign w_end       = ({1'b0, r_idx} == (len - LW'(1)));
    assign w_last_pass = (r_pass == (rep - RW'(1)));
    assign final_hs    = w_hs & w_end & w_last_pass;
    // Address of the beat that follows the current one (0 on load or wrap).
    assign rd_addr     = (load | w_end) ? '0 : r_idx + AW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_pass  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_fin   <= 1'b0;
        end else if (load) begin
            r_idx   <= '0;
            r_pass  <= '0;
            r_valid <= 1'b1;
            r_last  <= (len == LW'(1));
            r_data  <= rd_data;
            r_fin   <= 1'b0;
        end else if (w_hs) begin
            if (w_end) begin
                if (w_last_pass) begin
                    r_valid <= 1'b0;
                    r_fin   <= 1'b1;
                end else begin
                    r_idx  <= '0;
                    r_pass <= r_pass + RW'(1);
                    r_data <= rd_data;
                    r_last <= (len == LW'(1));
                end
            end else begin
                r_idx  <= r_idx + AW'(1);
                r_data <= rd_data;
                r_last <= ((LW'(r_idx) + LW'(2)) == len);
            end
        end
    end

    assign tdata  = r_data;
    assign tvalid = r_valid;
    assign tlast  = r_last;
    assign fin    = r_fin;

endmodule

module grid_scale_stream_source #(
    parameter int DATA_WIDTH   = 16,
    parameter int SCALE_WIDTH  = 16,
    parameter int GRID_DEPTH   = 8,
    parameter int REPEAT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_wr_en,
    input  logic [$clog2(GRID_DEPTH)-1:0]   cfg_wr_addr,
    input  logic [DATA_WIDTH-1:0]           cfg_wr_grid,
    input  logic [SCALE_WIDTH-1:0]          cfg_wr_scle,
    input  logic [$clog2(GRID_DEPTH):0]     cfg_grid_len,
    input  logic [REPEAT_WIDTH-1:0]         cfg_repeat,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            err_cfg,
    output logic [DATA_WIDTH-1:0]           m_axis_grid_tdata,
    output logic                            m_axis_grid_tvalid,
    input  logic                            m_axis_grid_tready,
    output logic                            m_axis_grid_tlast,
    output logic [SCALE_WIDTH-1:0]          m_axis_scle_tdata,
    output logic                            m_axis_scle_tvalid,
    input  logic                            m_axis_scle_tready,
    output logic                            m_axis_scle_tlast
);

    localparam int AW = $clog2(GRID_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] c_grid_depth = LW'(GRID_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_WIDTH-1:0]   r_grid_mem [GRID_DEPTH];
    logic [SCALE_WIDTH-1:0]  r_scle_mem [GRID_DEPTH];
    logic [LW-1:0]           r_len;
    logic [REPEAT_WIDTH-1:0] r_repeat;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;

    logic                    w_cfg_ok;
    logic                    w_accept;
    logic [LW-1:0]           w_len;
    logic [REPEAT_WIDTH-1:0] w_rep;
    logic [AW-1:0]           w_g_addr;
    logic [AW-1:0]           w_s_addr;
    logic                    w_g_fin;
    logic                    w_s_fin;
    logic                    w_g_final_hs;
    logic                    w_s_final_hs;
    logic                    w_all_fin;

    assign w_cfg_ok = (cfg_grid_len != '0) && (cfg_grid_len <= c_grid_depth) &&
                      (cfg_repeat != '0);
    assign w_accept = (r_state == S_IDLE) && start && w_cfg_ok;
    // On the accept cycle the channels load straight from the live config.
    assign w_len    = w_accept ? cfg_grid_len : r_len;
    assign w_rep    = w_accept ? cfg_repeat   : r_repeat;
    assign w_all_fin = (w_g_fin | w_g_final_hs) & (w_s_fin | w_s_final_hs);

    // Table is deliberately not reset; it only accepts writes while idle.
    always_ff @(posedge clk) begin
        if (cfg_wr_en && (r_state == S_IDLE)) begin
            r_grid_mem[cfg_wr_addr] <= cfg_wr_grid;
            r_scle_mem[cfg_wr_addr] <= cfg_wr_scle;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_next = S_RUN;
            S_RUN:   if (w_all_fin) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len    <= '0;
            r_repeat <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len    <= cfg_grid_len;
                r_repeat <= cfg_repeat;
            end
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (w_state_next == S_DONE);
            r_err  <= (r_state == S_IDLE) && start && !w_cfg_ok;
        end
    end

    grid_scale_stream_chan #(
        .WIDTH (DATA_WIDTH),
        .AW    (AW),
        .LW    (LW),
        .RW    (REPEAT_WIDTH)
    ) u_grid_chan (
        .clk      (clk),
        .rst      (rst),
        .load     (w_accept),
        .len      (w_len),
        .rep      (w_rep),
        .rd_data  (r_grid_mem[w_g_addr]),
        .tready   (m_axis_grid_tready),
        .rd_addr  (w_g_addr),
        .tdata    (m_axis_grid_tdata),
        .tvalid   (m_axis_grid_tvalid),
        .tlast    (m_axis_grid_tlast),
        .fin      (w_g_fin),
        .final_hs (w_g_final_hs)
    );

    grid_scale_stream_chan #(
        .WIDTH (SCALE_WIDTH),
        .AW    (AW),
        .LW    (LW),
        .RW    (REPEAT_WIDTH)
    ) u_scle_chan (
        .clk      (clk),
        .rst      (rst),
        .load     (w_accept),
        .len      (w_len),
        .rep      (w_rep),
        .rd_data  (r_scle_mem[w_s_addr]),
        .tready   (m_axis_scle_tready),
        .rd_addr  (w_s_addr),
        .tdata    (m_axis_scle_tdata),
        .tvalid   (m_axis_scle_tvalid),
        .tlast    (m_axis_scle_tlast),
        .fin      (w_s_fin),
        .final_hs (w_s_final_hs)
    );

    assign busy    = r_busy;
    assign done    = r_done;
    assign err_cfg = r_err;

endmodule
`default_nettype wire

// File: tb/tb_grid_scale_stream_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_scale_stream_source
// Purpose  : Randomized self-checking bench against a table-replay model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grid_scale_stream_source;

    localparam int GD = 8;
    localparam int AW = 3;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_wr_en;
    logic [AW-1:0] cfg_wr_addr;
    logic [15:0]   cfg_wr_grid;
    logic [15:0]   cfg_wr_scle;
    logic [LW-1:0] cfg_grid_len;
    logic [15:0]   cfg_repeat;
    logic          start;
    logic          busy, done, err_cfg;
    logic [15:0]   g_data, s_data;
    logic          g_valid, g_ready, g_last;
    logic          s_valid, s_ready, s_last;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] m_grid [GD];
    logic [15:0] m_scle [GD];

    always #5 clk = ~clk;

    grid_scale_stream_source #(
        .DATA_WIDTH   (16),
        .SCALE_WIDTH  (16),
        .GRID_DEPTH   (GD),
        .REPEAT_WIDTH (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_wr_en          (cfg_wr_en),
        .cfg_wr_addr        (cfg_wr_addr),
        .cfg_wr_grid        (cfg_wr_grid),
        .cfg_wr_scle        (cfg_wr_scle),
        .cfg_grid_len       (cfg_grid_len),
        .cfg_repeat         (cfg_repeat),
        .start              (start),
        .busy               (busy),
        .done               (done),
        .err_cfg            (err_cfg),
        .m_axis_grid_tdata  (g_data),
        .m_axis_grid_tvalid (g_valid),
        .m_axis_grid_tready (g_ready),
        .m_axis_grid_tlast  (g_last),
        .m_axis_scle_tdata  (s_data),
        .m_axis_scle_tvalid (s_valid),
        .m_axis_scle_tready (s_ready),
        .m_axis_scle_tlast  (s_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err_cfg, 0);
        chk({tag, "_gvalid"}, g_valid, 0);
        chk({tag, "_svalid"}, s_valid, 0);
        chk({tag, "_glast"}, g_last, 0);
        chk({tag, "_slast"}, s_last, 0);
        chk({tag, "_gdata"}, g_data, 0);
        chk({tag, "_sdata"}, s_data, 0);
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic write_tbl(input int addr, input logic [15:0] g, input logic [15:0] s);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = AW'(addr);
        cfg_wr_grid = g;
        cfg_wr_scle = s;
        m_grid[addr] = g;
        m_scle[addr] = s;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    // Expected beat k of a frame is table[k mod len], last when k mod len == len-1.
    task automatic chan_step(input string nm, input bit is_g, input logic v,
                             input logic [15:0] d, input logic l, input logic rdy,
                             input int len, input int total, inout int k,
                             inout bit stall, inout logic [15:0] pd, inout logic pl);
        logic [15:0] e;
        if (v) begin
            if (stall) begin
                chk({nm, "_hold_data"}, d, pd);
                chk({nm, "_hold_last"}, l, pl);
            end
            if (k < total) begin
                e = is_g ? m_grid[k % len] : m_scle[k % len];
                chk({nm, "_data"}, d, e);
                chk({nm, "_last"}, l, ((k % len) == len - 1));
                if (rdy) begin
                    k++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    pd = d;
                    pl = l;
                end
            end else begin
                chk({nm, "_valid_extra"}, v, 0);
            end
        end else begin
            stall = 1'b0;
            if (k < total) chk({nm, "_valid"}, v, 1);
        end
    endtask

    task automatic run_frame(input int len, input int rep, input int g_pct,
                             input int s_pct, input bit inject);
        int          total;
        int          k_g, k_s;
        bit          g_st, s_st, exp_done, got_done;
        logic [15:0] g_pd, s_pd;
        logic        g_pl, s_pl;
        total = len * rep;
        k_g = 0; k_s = 0; g_st = 0; s_st = 0; exp_done = 0; got_done = 0;
        g_pd = '0; s_pd = '0; g_pl = 0; s_pl = 0;
        cfg_grid_len = LW'(len);
        cfg_repeat   = 16'(rep);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (inject && cyc == 3) begin
                start        = 1'b1;
                cfg_wr_en    = 1'b1;
                cfg_wr_addr  = '0;
                cfg_wr_grid  = 16'h7FFF;
                cfg_wr_scle  = 16'h7FFF;
                cfg_grid_len = (len == 1) ? LW'(2) : LW'(1);
                cfg_repeat   = 16'd7;
            end else if (inject && cyc == 4) begin
                start     = 1'b0;
                cfg_wr_en = 1'b0;
            end
            g_ready = ($urandom_range(99) < g_pct);
            s_ready = ($urandom_range(99) < s_pct);
            chk("done", done, exp_done);
            if (exp_done) begin
                got_done = 1;
                if (g_pct >= 100 && s_pct >= 100) chk("latency", cyc, total);
                break;
            end
            chk("busy", busy, 1);
            chan_step("grid", 1, g_valid, g_data, g_last, g_ready, len, total, k_g, g_st, g_pd, g_pl);
            chan_step("scle", 0, s_valid, s_data, s_last, s_ready, len, total, k_s, s_st, s_pd, s_pl);
            if (k_g == total && k_s == total) exp_done = 1;
        end
        if (!got_done) chk("timeout", 0, 1);
        start     = 1'b0;
        cfg_wr_en = 1'b0;
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        chk("gvalid_after", g_valid, 0);
        chk("svalid_after", s_valid, 0);
    endtask

    task automatic cfg_err(input int len, input int rep);
        cfg_grid_len = LW'(len);
        cfg_repeat   = 16'(rep);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err_cfg, 1);
        chk("err_busy", busy, 0);
        chk("err_gvalid", g_valid, 0);
        chk("err_svalid", s_valid, 0);
        @(negedge clk);
        chk("err_clear", err_cfg, 0);
        chk("err_busy2", busy, 0);
        chk("err_gvalid2", g_valid, 0);
    endtask

    initial begin
        rst = 1'b0;
        cfg_wr_en = 0; cfg_wr_addr = '0; cfg_wr_grid = '0; cfg_wr_scle = '0;
        cfg_grid_len = '0; cfg_repeat = '0; start = 0; g_ready = 0; s_ready = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Q4.12 grid -2,-1,0,1 with unit scale
        write_tbl(0, 16'hE000, 16'h1000);
        write_tbl(1, 16'hF000, 16'h1000);
        write_tbl(2, 16'h0000, 16'h1000);
        write_tbl(3, 16'h1000, 16'h1000);
        run_frame(4, 3, 100, 100, 0);

        run_frame(4, 3, 50, 100, 0);

        cfg_err(0, 3);
        cfg_err(9, 3);
        cfg_err(4, 0);

        run_frame(4, 3, 100, 100, 1);
        run_frame(1, 1, 100, 100, 0);

        // Reset in the middle of a frame, after five beats
        cfg_grid_len = LW'(4);
        cfg_repeat   = 16'd3;
        start        = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        g_ready = 1'b1;
        s_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_gdata", g_data, m_grid[1]);
        #2 rst = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame(4, 2, 100, 100, 0);

        run_frame(1, 1, 100, 100, 0);

        for (int a = 0; a < GD; a++) write_tbl(a, 16'($urandom), 16'($urandom));
        for (int f = 0; f < 10; f++)
            run_frame($urandom_range(1, GD), $urandom_range(1, 4),
                      $urandom_range(30, 100), $urandom_range(30, 100), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/grid_scale_stream_source.md
# grid_scale_stream_source

Grid/scale stream transmitter that drives the grid and scale AXI-Stream inputs of the RSWAF data processor. It holds a small table of (grid point, scale) pairs loaded through a configuration write port. On `start` it replays the table once per data sample, so the activation stage receives one grid/scale beat per grid point for every input sample. The two channels run independently, each with its own handshake.

## Interface
- `DATA_WIDTH`, 16: grid point width, signed fixed point.
- `SCALE_WIDTH`, 16: scale width, signed fixed point.
- `GRID_DEPTH`, 8: table entries; power of two, ≥2.
- `REPEAT_WIDTH`, 16: width of the pass-count register.
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `cfg_wr_en`  in  1: table write strobe.
- `cfg_wr_addr`  in  $clog2(GRID_DEPTH): table write index.
- `cfg_wr_grid`  in  DATA_WIDTH: grid value to write.
- `cfg_wr_scle`  in  SCALE_WIDTH: scale value to write.
- `cfg_grid_len`  in  $clog2(GRID_DEPTH)+1: points per pass, valid range 1..GRID_DEPTH.
- `cfg_repeat`  in  REPEAT_WIDTH: passes per frame (number of data samples), ≥1.
- `start`  in  1: frame start pulse.
- `busy`  out  1: high from start acceptance until `done`.
- `done`  out  1: one-cycle completion pulse.
- `err_cfg`  out  1: one-cycle pulse when `start` is rejected.
- `m_axis_grid_tdata`  out  DATA_WIDTH: grid beat.
- `m_axis_grid_tvalid`  out  1: grid beat valid.
- `m_axis_grid_tready`  in  1: grid beat accepted.
- `m_axis_grid_tlast`  out  1: marks the last point of each pass.
- `m_axis_scle_tdata`  out  SCALE_WIDTH: scale beat.
- `m_axis_scle_tvalid`  out  1: scale beat valid.
- `m_axis_scle_tready`  in  1: scale beat accepted.
- `m_axis_scle_tlast`  out  1: marks the last point of each pass.

## Operation
- **Table**
  - Written when `cfg_wr_en` is high and the block is in IDLE.
  - Writes during RUN or DONE are dropped.
  - Table contents are not reset.
- **FSM states**
  - IDLE → RUN: `start` is high and the latched config is legal.
  - RUN → DONE: both channels have completed their final handshake.
  - DONE → IDLE: unconditional, one cycle later.
- **Start handling**
  - On acceptance, `cfg_grid_len` and `cfg_repeat` are latched. Later changes to these inputs have no effect on the running frame.
  - `start` with `cfg_grid_len` = 0, `cfg_grid_len` > GRID_DEPTH, or `cfg_repeat` = 0: the FSM stays in IDLE and `err_cfg` pulses for one cycle.
  - `start` during RUN or DONE is ignored and produces no error.
- **Per-channel sequencing** (grid and scale are identical and decoupled)
  - Each channel has a point index `idx` and a pass counter `pass`.
  - Beat content: `tdata` = table[idx] field for that channel; `tlast` = (idx == len-1).
  - On a handshake (`tvalid & tready`):
    - If idx < len-1: idx increments.
    - Else: idx wraps to 0 and pass increments.
    - The final beat is idx == len-1 with pass == repeat-1. After it, that channel drops `tvalid` and waits.
  - One channel stalling never blocks the other.
- **AXIS rules**
  - Outputs come from registers.
  - While `tvalid` is high and `tready` is low, `tdata` and `tlast` hold stable.
  - `tvalid` is never withdrawn before its handshake.
- **Counters**: `pass` is REPEAT_WIDTH bits and cannot overflow, because `cfg_repeat` ≥ 1.

## Timing
- **Reset values**: all outputs are 0 (`busy`, `done`, `err_cfg`, both `tvalid`, both `tlast`, both `tdata`), state is IDLE, all counters are 0.
- **Reset mid-frame**: everything clears immediately and asynchronously. There is no `done` pulse. The frame must be restarted.
- **Start latency**
  - `start` sampled at edge N.
  - `busy` and both `tvalid` high after edge N, with table[0] on `tdata`.
- **Throughput**: one beat per cycle per channel while `tready` is held high. A frame is len×repeat beats per channel.
- **Channel completion**: the last handshake occurs at edge M, and that channel's `tvalid` is low after edge M.
- **Done**
  - Edge M is the later of the two channels' final handshakes.
  - FSM is in DONE after edge M; `done` is high for that one cycle.
  - `busy` is low and the FSM is back in IDLE after edge M+1.
  - A `start` during the `done` cycle is ignored.
- **Config write latency**: a write at edge N is visible to a `start` sampled at edge N+1.
- **Minimum frame**: with len = 1 and repeat = 1, each channel sends one beat with `tlast` = 1.

## Test plan
- **Basic frame**
  - Load grid {-2,-1,0,1} (Q4.12: 0xE000, 0xF000, 0x0000, 0x1000) and scale 0x1000 for all entries; len = 4, repeat = 3; hold both `tready` high.
  - Required: 12 beats per channel in table order; `tlast` on beats 4, 8, 12; `done` one cycle after beat 12.
- **Backpressure**
  - Grid `tready` random at 50%, scale `tready` held high.
  - Required: `tdata`/`tlast` stable while stalled; scale finishes first; `done` asserts only after the last grid handshake.
- **Config errors**
  - `start` with len = 0, then with len = 9 (GRID_DEPTH = 8), then with repeat = 0.
  - Required: `err_cfg` pulses each time; `busy` stays low; no beats emitted.
- **Busy interactions**
  - Mid-frame: `start` pulse plus a table write to addr 0 with value 0x7FFF.
  - Required: the frame is unaffected and the write is dropped; the next frame emits the original table[0].
- **Reset mid-frame**
  - Drop `rst` after 5 beats.
  - Required: all outputs 0 immediately; after release, a new `start` replays from table[0], pass 0.
- **Minimal frame**
  - len = 1, repeat = 1.
  - Required: a single beat per channel with `tlast` = 1; `done` one cycle after the later handshake.
